// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin scheduler sharing one UART transmitter core among
//            NREQ byte requesters. Granted bytes go through a small FIFO and
//            are launched into the core with a send/busy handshake, followed
//            by a fixed inter-character gap. A busy timeout sets a sticky fault.
//            Optional macro UART_TX_SCHED_PRIO_EN gives requester 0 fixed
//            highest priority; requesters 1..NREQ-1 then round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NREQ       = 2,
    parameter int DSIZE      = 8,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int BUSY_TO    = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    output logic [DSIZE-1:0]          tx_din,
    output logic                      tx_send,
    input  logic                      tx_busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      fault
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMAX = (BUSY_TO > GAP_CYCLES) ? BUSY_TO : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
`ifdef UART_TX_SCHED_PRIO_EN
    localparam bit C_PRIO = 1'b1;
`else
    localparam bit C_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_cnt, w_cnt_nxt;
    logic [PW-1:0]         r_ptr;
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [LW-1:0]         r_count;
    logic [DSIZE-1:0]      r_mem [DEPTH];
    logic [DSIZE-1:0]      r_din;
    logic                  r_send, r_fault;
    logic                  w_can_grant, w_gnt_vld, w_pop, w_timeout;
    logic [PW-1:0]         w_gnt_idx;
    logic [DSIZE-1:0]      w_push_data;
    int                    w_cand;

    assign w_can_grant = enable && !flush && (r_count < LW'(DEPTH));
    assign w_push_data = req_data[w_gnt_idx*DSIZE +: DSIZE];

    // Arbiter: pick the first requester after the last granted one.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = 0;
        gnt       = '0;
        if (w_can_grant) begin
            if (C_PRIO && req[0]) begin
                w_gnt_vld = 1'b1;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    w_cand = int'(r_ptr) + k;
                    if (w_cand >= NREQ) w_cand = w_cand - NREQ;
                    if (!w_gnt_vld && req[w_cand] && !(C_PRIO && w_cand == 0)) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = PW'(w_cand);
                    end
                end
            end
            if (w_gnt_vld) gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Launch sequencer: next state, timer and pop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // flush wins over a pop in the same cycle
                if (enable && !flush && (r_count != '0) && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                    w_cnt_nxt   = '0;
                end else if (int'(r_cnt) + 1 >= BUSY_TO) begin
                    // the byte is dropped, not retried
                    w_timeout   = 1'b1;
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end
            end
            GAP: begin
                // a zero gap still spends one cycle here before IDLE
                if (int'(r_cnt) + 1 >= GAP_CYCLES) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, timer, launch outputs and sticky fault.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_send  <= 1'b0;
            r_din   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_send  <= w_pop;
            if (w_pop)     r_din   <= r_mem[r_rptr];
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    // Round-robin pointer and FIFO pointers/occupancy.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ptr   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_gnt_vld) r_ptr <= w_gnt_idx;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_gnt_vld) r_wptr <= r_wptr + 1'b1;
                if (w_pop)     r_rptr <= r_rptr + 1'b1;
                if (w_gnt_vld && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_gnt_vld && w_pop) r_count <= r_count - 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge pclk) begin
        if (w_gnt_vld) r_mem[r_wptr] <= w_push_data;
    end

    assign tx_send = r_send;
    assign tx_din  = r_din;
    assign level   = r_count;
    assign fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Directed self-checking bench for uart_tx_sched with a simple
//            behavioural transmitter core (busy for FRAME cycles per send).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NREQ  = 2;
    localparam int DSIZE = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int BTO   = 16;
    localparam int FRAME = 20;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        enable, flush;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  gnt;
    logic [7:0]  tx_din;
    logic        tx_send, tx_busy;
    logic [2:0]  level;
    logic        fault;

    logic        core_en, busy_force, core_busy;
    int          core_cnt;
    int          total = 0;
    int          bad   = 0;

    always #5 pclk = ~pclk;

    uart_tx_sched #(
        .NREQ(NREQ), .DSIZE(DSIZE), .DEPTH(DEPTH),
        .GAP_CYCLES(GAP), .BUSY_TO(BTO)
    ) dut (
        .pclk(pclk), .presetn(presetn), .enable(enable), .flush(flush),
        .req(req), .req_data(req_data), .gnt(gnt), .tx_din(tx_din),
        .tx_send(tx_send), .tx_busy(tx_busy), .level(level), .fault(fault)
    );

    // Behavioural core: busy for FRAME cycles starting the edge after a send.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (tx_send && core_en && !core_busy) begin
            core_busy <= 1'b1;
            core_cnt  <= FRAME - 1;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end else begin
            core_busy <= 1'b0;
        end
    end
    assign tx_busy = core_busy | busy_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #2;
        end
    endtask

    task automatic do_reset();
        req = '0; req_data = '0; enable = 1'b0; flush = 1'b0;
        busy_force = 1'b0; core_en = 1'b1;
        presetn = 1'b0;
        #3;
        presetn = 1'b1;
        cyc(1);
    endtask

    task automatic wait_send(input int maxc, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < maxc && !seen) begin
            cyc(1);
            n++;
            if (tx_send) seen = 1'b1;
        end
    endtask

    int         n;
    bit         seen;
    logic [1:0] gl [4];
    logic [7:0] dl [4];
    int         ng, ns, maxl;

    initial begin
        @(posedge pclk);
        #2;
        do_reset();

        // ---- reset values
        check("rst_gnt", 32'(gnt), 0);
        check("rst_send", 32'(tx_send), 0);
        check("rst_din", 32'(tx_din), 0);
        check("rst_level", 32'(level), 0);
        check("rst_fault", 32'(fault), 0);

        // ---- single byte from requester 0, then spacing to the next launch
        enable = 1'b1; req = 2'b01; req_data = 16'h0055;
        #1;
        check("t1_gnt", 32'(gnt), 32'h1);
        cyc(1);
        req = 2'b00;
        #1;
        check("t1_gnt_once", 32'(gnt), 0);
        check("t1_level", 32'(level), 1);
        cyc(1);
        check("t1_send", 32'(tx_send), 1);
        check("t1_din", 32'(tx_din), 32'h55);
        req = 2'b01; req_data = 16'h0066;
        cyc(1);
        req = 2'b00;
        check("t1_send_pulse", 32'(tx_send), 0);
        // n counts cycles from the edge where busy rose to the next send
        wait_send(60, n, seen);
        check("t1_second_seen", 32'(seen), 1);
        check("t1_spacing_ok", 32'(n >= FRAME + GAP), 1);
        check("t1_second_din", 32'(tx_din), 32'h66);

        // ---- two held requesters: pointer starts at 0, so requester 1 first
        do_reset();
        enable = 1'b1; req = 2'b11; req_data = 16'hB1A0;
        ng = 0; ns = 0; maxl = 0;
        #1;
        for (int c = 0; c < 110; c++) begin
            if (gnt != 2'b00 && ng < 4) begin gl[ng] = gnt; ng++; end
            if (tx_send && ns < 4) begin dl[ns] = tx_din; ns++; end
            if (int'(level) > maxl) maxl = int'(level);
            cyc(1);
        end
        req = 2'b00;
        check("t2_g0", 32'(gl[0]), 32'h2);
        check("t2_g1", 32'(gl[1]), 32'h1);
        check("t2_g2", 32'(gl[2]), 32'h2);
        check("t2_g3", 32'(gl[3]), 32'h1);
        check("t2_d0", 32'(dl[0]), 32'hB1);
        check("t2_d1", 32'(dl[1]), 32'hA0);
        check("t2_d2", 32'(dl[2]), 32'hB1);
        check("t2_d3", 32'(dl[3]), 32'hA0);
        check("t2_maxlevel", 32'(maxl), 4);

        // ---- fill while core busy elsewhere, freeze, then resume
        do_reset();
        enable = 1'b1; busy_force = 1'b1; req = 2'b11; req_data = 16'hB1A0;
        cyc(6);
        check("t3_full", 32'(level), 4);
        check("t3_full_nognt", 32'(gnt), 0);
        check("t3_busy_nosend", 32'(tx_send), 0);
        enable = 1'b0; busy_force = 1'b0;
        cyc(3);
        check("t3_dis_nognt", 32'(gnt), 0);
        check("t3_dis_nosend", 32'(tx_send), 0);
        check("t3_dis_level", 32'(level), 4);
        enable = 1'b1;
        cyc(1);
        check("t3_pop_send", 32'(tx_send), 1);
        check("t3_pop_din", 32'(tx_din), 32'hB1);
        check("t3_pop_level", 32'(level), 3);
        check("t3_refill_gnt", 32'(gnt), 32'h2);
        cyc(1);
        check("t3_refill_level", 32'(level), 4);

        // ---- core never goes busy: timeout fault, byte dropped, next launches
        do_reset();
        core_en = 1'b0; enable = 1'b1; req = 2'b01; req_data = 16'h0011;
        cyc(1);
        req_data = 16'h0022;
        cyc(1);
        req = 2'b00;
        check("t4_send", 32'(tx_send), 1);
        check("t4_din", 32'(tx_din), 32'h11);
        cyc(BTO - 1);
        check("t4_nofault_yet", 32'(fault), 0);
        cyc(1);
        check("t4_fault", 32'(fault), 1);
        wait_send(10, n, seen);
        check("t4_next_seen", 32'(seen), 1);
        check("t4_next_din", 32'(tx_din), 32'h22);
        check("t4_sticky", 32'(fault), 1);

        // ---- flush during WAIT_DONE with three bytes queued
        do_reset();
        enable = 1'b1; req = 2'b01; req_data = 16'h0031;
        cyc(4);
        req = 2'b00;
        check("t5_level3", 32'(level), 3);
        cyc(3);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("t5_flushed", 32'(level), 0);
        wait_send(50, n, seen);
        check("t5_no_send", 32'(seen), 0);
        check("t5_frame_done", 32'(tx_busy), 0);

        // ---- asynchronous reset in WAIT_DONE
        do_reset();
        enable = 1'b1; req = 2'b01; req_data = 16'h005A;
        cyc(3);
        req = 2'b00;
        cyc(3);
        check("t6_pre_level", 32'(level), 2);
        check("t6_pre_din", 32'(tx_din), 32'h5A);
        presetn = 1'b0;
        #1;
        check("t6_async_zero", 32'({gnt, tx_send, tx_din, level, fault}), 0);
        #1;
        presetn = 1'b1;
        req = 2'b01; req_data = 16'h0077;
        #1;
        check("t6_first_gnt", 32'(gnt), 32'h1);
        cyc(1);
        req = 2'b00;
        check("t6_level", 32'(level), 1);

`ifdef UART_TX_SCHED_PRIO_EN
        // ---- fixed priority for requester 0
        do_reset();
        enable = 1'b1; req = 2'b11; req_data = 16'hB1A0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("t7_prio_gnt", 32'(gnt), 32'h1);
            cyc(1);
        end
        req = 2'b10;
        #1;
        check("t7_req1_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
